alu_sequencer: RTL and testbench
================================

# alu_sequencer

Pipelined command front-end that issues operations to the combinational ALU and returns its results. Commands arrive on a valid/ready port. The sequencer registers the operands and opcode onto the ALU input pins and samples the ALU outputs one cycle later. Results, flags and a tag are queued in a small response FIFO drained by a valid/ready port. It sits between the decode/control logic and the ALU, and absorbs back-pressure so that the ALU itself stays purely combinational.

## Interface
- DEPTH, 4, response FIFO entries (power of two, ≥2)
- TAG_W, 4, command tag width
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer accepts command this cycle
- cmd_opcode  in  5  ALU opcode (0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra)
- cmd_shamt  in  5  shift amount
- cmd_a, cmd_b  in  32  operands
- cmd_tag  in  TAG_W  returned unchanged with the result
- data_operandA, data_operandB  out  32  registered ALU operands
- ctrl_ALUopcode, ctrl_shiftamt  out  5  registered ALU controls
- data_result  in  32  ALU result
- isNotEqual, isLessThan, overflow  in  1  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  32  result
- rsp_flags  out  3  {overflow, isLessThan, isNotEqual}
- rsp_err  out  1  opcode was illegal (6..31)
- rsp_tag  out  TAG_W  tag of the command

## Operation
- Stage 1 (issue): on a cmd_valid&&cmd_ready edge, load cmd_a, cmd_b, cmd_opcode[4:0] and cmd_shamt into the ALU-side output registers, load cmd_tag into tag_q, and set issue_v=1. With no accept, issue_v=0. ALU-side registers hold their last values.
- Stage 2 (capture): while issue_v=1, push {data_result, flags, err, tag_q} into the FIFO at the next edge.
- Illegal opcode (≥6): push rsp_data=0, rsp_flags=0, rsp_err=1. The ALU outputs are ignored.
- Opcodes 2..5: overflow is forced to 0. isNotEqual and isLessThan pass through; they always reflect A−B.
- Credit rule: cmd_ready = reset_n && (count + issue_v < DEPTH). An accepted command therefore always has a FIFO slot and the capture never stalls.
- FIFO: a push and a pop in the same cycle leave count unchanged. Ordering is strictly FIFO. rsp_* come from the head entry and are stable while rsp_valid && !rsp_ready.
- rsp_valid = (count != 0).
- States: the sequencer has no explicit FSM. Its state is issue_v plus the FIFO count, 0..DEPTH. It is Full at count=DEPTH, and Stalled when count + issue_v = DEPTH.

## Timing
- Reset (async assert): issue_v=0, count=0, FIFO pointers=0. All ALU-side registers and rsp_* read 0. cmd_ready=0 while reset_n is low.
- Reset asserted mid-operation drops any in-flight command and all queued responses.
- Latency: command accepted at edge N → ALU inputs valid after N → captured at N+1 → rsp_valid high after N+1 (2 cycles) when the FIFO was empty.
- Throughput: 1 command/cycle while rsp_ready=1.
- With rsp_ready=0, DEPTH back-to-back commands are accepted. cmd_ready then drops to 0 in the cycle after the last accept. No result is ever lost or duplicated.
- Pop at a full FIFO raises cmd_ready in the same cycle only if issue_v=0. Otherwise it raises one cycle later.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.

## Structure
- A shared package holds the opcode constants (OP_ADD..OP_SRA), OP_LAST=5, the flag bit indices, and the response entry struct {data, flags, err, tag}.
- One sub-module, rsp_fifo: parameterized DEPTH×width synchronous FIFO with count, push/pop, and async active-low reset.
- The top level contains the issue registers, the capture/masking logic and the credit computation.

## Test plan
- Accept add A=0x7FFFFFFF, B=1, tag=3 with rsp_ready=1. Two cycles later expect rsp_data=0x80000000, rsp_flags=3'b101, rsp_err=0, tag=3.
- Accept sub A=5, B=9. Expect rsp_data=0xFFFFFFFC and rsp_flags=3'b011 (lt, ne, no ovf). Then accept sll A=1, shamt=31: expect 0x80000000 with overflow bit 0.
- Accept opcode 7, tag=9. Expect rsp_err=1, rsp_data=0, rsp_flags=0, tag=9, and no hang.
- Hold rsp_ready=0 and stream commands. Expect exactly 4 accepts, then cmd_ready=0. Release rsp_ready and expect 4 in-order responses, tags 0..3, each stable while stalled.
- Set rsp_ready=1 with a full FIFO and issue_v=0 while cmd_valid is held. Expect simultaneous pop and accept with count staying at DEPTH−1+1 and no drop.
- Pull reset_n low while 2 entries are queued and one command is in issue. Outputs go to 0 immediately. After release expect rsp_valid=0 and cmd_ready=1.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode constants, flag positions and the response entry layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_sequencer_pkg;

  localparam int DATA_W = 32;
  localparam int OPC_W  = 5;
  // The response struct carries the tag, so its width lives here.
  localparam int TAG_W  = 4;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd2;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd3;
  localparam logic [OPC_W-1:0] OP_SLL  = 5'd4;
  localparam logic [OPC_W-1:0] OP_SRA  = 5'd5;
  localparam logic [OPC_W-1:0] OP_LAST = 5'd5;

  // Bit positions inside the 3-bit flags field {overflow, isLessThan, isNotEqual}.
  localparam int FLAG_NE  = 0;
  localparam int FLAG_LT  = 1;
  localparam int FLAG_OVF = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [2:0]        flags;
    logic              err;
    logic [TAG_W-1:0]  tag;
  } rsp_entry_t;

  function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
    return op <= OP_LAST;
  endfunction

  // Only the arithmetic ops produce a meaningful overflow flag.
  function automatic logic op_has_ovf(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, ALU-pin and response signals of the sequencer, bundled.
// Latency: n/a (wires only).
// Backpressure: cmd_ready / rsp_ready valid-ready handshakes.
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OPC_W-1:0]  cmd_opcode;
  logic [4:0]        cmd_shamt;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [TAG_W-1:0]  cmd_tag;

  logic [DATA_W-1:0] data_operandA;
  logic [DATA_W-1:0] data_operandB;
  logic [OPC_W-1:0]  ctrl_ALUopcode;
  logic [4:0]        ctrl_shiftamt;
  logic [DATA_W-1:0] data_result;
  logic              isNotEqual;
  logic              isLessThan;
  logic              overflow;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [2:0]        rsp_flags;
  logic              rsp_err;
  logic [TAG_W-1:0]  rsp_tag;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_shamt, cmd_a, cmd_b, cmd_tag,
    output cmd_ready,
    output data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
    input  data_result, isNotEqual, isLessThan, overflow,
    output rsp_valid, rsp_data, rsp_flags, rsp_err, rsp_tag,
    input  rsp_ready
  );

  // Control logic plus ALU side.
  modport master (
    output cmd_valid, cmd_opcode, cmd_shamt, cmd_a, cmd_b, cmd_tag,
    input  cmd_ready,
    input  data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
    output data_result, isNotEqual, isLessThan, overflow,
    input  rsp_valid, rsp_data, rsp_flags, rsp_err, rsp_tag,
    output rsp_ready
  );

endinterface

// File: rtl/alu_sequencer_rsp_fifo.sv
// DEPTH x W synchronous FIFO with occupancy count.
// Latency: a push is visible at the head one cycle later when empty.
// Backpressure: pop on empty and push on full (without a pop) are ignored.
module rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [W-1:0]           wdat,
  input  logic                   pop,
  output logic [W-1:0]           rdat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Next-state for storage, pointers and count; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_C) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdat  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_sequencer.sv
// Registers commands onto the ALU pins, captures results next cycle into a response FIFO.
// Latency: accept at edge N, capture at N+1, rsp_valid after N+1 when the FIFO was empty.
// Backpressure: credit-based cmd_ready guarantees a FIFO slot for every issued command.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  alu_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              issue_v_q, issue_v_d;

  logic              cmd_ready;
  logic              accept;
  logic              rsp_valid;
  logic              pop;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    used;
  rsp_entry_t        cap_e;
  rsp_entry_t        head;

  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && bus.rsp_ready;
  assign used      = {1'b0, count} + (CNT_W + 1)'(issue_v_q);

  // Credit: a slot must exist for the command now in issue plus the new one. A pop
  // frees a slot early only when nothing is in issue (i.e. the FIFO itself is full).
  assign cmd_ready = reset_n && ((used < DEPTH_C) || (pop && !issue_v_q));
  assign accept    = bus.cmd_valid && cmd_ready;

  // Issue stage: ALU-side registers load on accept and otherwise hold.
  always_comb begin
    opa_d     = opa_q;
    opb_d     = opb_q;
    opc_d     = opc_q;
    shamt_d   = shamt_q;
    tag_d     = tag_q;
    issue_v_d = accept;
    if (accept) begin
      opa_d   = bus.cmd_a;
      opb_d   = bus.cmd_b;
      opc_d   = bus.cmd_opcode;
      shamt_d = bus.cmd_shamt;
      tag_d   = bus.cmd_tag;
    end
  end

  // Issue registers, cleared asynchronously so a reset drops the in-flight command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opa_q     <= '0;
      opb_q     <= '0;
      opc_q     <= '0;
      shamt_q   <= '0;
      tag_q     <= '0;
      issue_v_q <= 1'b0;
    end else begin
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      opc_q     <= opc_d;
      shamt_q   <= shamt_d;
      tag_q     <= tag_d;
      issue_v_q <= issue_v_d;
    end
  end

  // Capture stage: mask ALU outputs for illegal ops and non-arithmetic overflow.
  always_comb begin
    cap_e     = '0;
    cap_e.tag = tag_q;
    if (!op_is_legal(opc_q)) begin
      cap_e.err = 1'b1;
    end else begin
      cap_e.data            = bus.data_result;
      cap_e.flags[FLAG_NE]  = bus.isNotEqual;
      cap_e.flags[FLAG_LT]  = bus.isLessThan;
      cap_e.flags[FLAG_OVF] = bus.overflow && op_has_ovf(opc_q);
    end
  end

  rsp_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (issue_v_q),
    .wdat    (cap_e),
    .pop     (pop),
    .rdat    (head),
    .count   (count)
  );

  assign bus.cmd_ready      = cmd_ready;
  assign bus.data_operandA  = opa_q;
  assign bus.data_operandB  = opb_q;
  assign bus.ctrl_ALUopcode = opc_q;
  assign bus.ctrl_shiftamt  = shamt_q;

  // Response outputs read zero whenever the FIFO is empty.
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_valid ? head.data  : '0;
  assign bus.rsp_flags = rsp_valid ? head.flags : '0;
  assign bus.rsp_err   = rsp_valid ? head.err   : 1'b0;
  assign bus.rsp_tag   = rsp_valid ? head.tag   : '0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, queue-based reference, random + directed stimulus.
// Latency: n/a.
// Backpressure: rsp_ready is driven randomly and in directed stall phases.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  alu_sequencer_if bus ();

  alu_sequencer #(.DEPTH(DEPTH)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stand-in for the external ALU. Illegal opcodes and non-arithmetic overflow
  // deliberately produce junk so the sequencer's masking is exercised.
  always_comb begin
    logic [31:0] a, b, r;
    a = bus.data_operandA;
    b = bus.data_operandB;
    r = a - b;
    bus.isNotEqual = (a != b);
    bus.isLessThan = ($signed(a) < $signed(b));
    bus.overflow   = (a[31] != b[31]) && (r[31] != a[31]);
    case (bus.ctrl_ALUopcode)
      5'd0: begin
        r = a + b;
        bus.overflow = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'd1: r = a - b;
      5'd2: begin r = a & b; bus.overflow = 1'b1; end
      5'd3: begin r = a | b; bus.overflow = 1'b1; end
      5'd4: r = a << bus.ctrl_shiftamt;
      5'd5: r = $signed(a) >>> bus.ctrl_shiftamt;
      default: begin
        r = a ^ b ^ 32'hA5A5_5A5A;
        bus.isNotEqual = 1'b1;
        bus.isLessThan = 1'b1;
        bus.overflow   = 1'b1;
      end
    endcase
    bus.data_result = r;
  end

  // Expected response from the command fields, using wide signed arithmetic.
  function automatic rsp_entry_t ref_rsp(input logic [4:0] op, input logic [4:0] sh,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] tag);
    rsp_entry_t r;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    r.tag = tag;
    if (op > 5'd5) begin
      r.err = 1'b1;
      return r;
    end
    r.flags[0] = (a != b);
    r.flags[1] = (sa < sb);
    s = 0;
    case (op)
      5'd0: s = sa + sb;
      5'd1: s = sa - sb;
      5'd2: s = longint'(a & b);
      5'd3: s = longint'(a | b);
      5'd4: s = longint'(a << sh);
      default: s = sa >>> sh;
    endcase
    r.data = s[31:0];
    if (op <= 5'd1) r.flags[2] = (s > 64'sd2147483647) || (s < -(64'sd2147483648));
    return r;
  endfunction

  // Reference state: queued responses, plus the one command in issue.
  rsp_entry_t  exp_q[$];
  bit          iss_v = 1'b0;
  rsp_entry_t  iss_e;
  logic [31:0] iss_a, iss_b;
  logic [4:0]  iss_op;
  bit          last_accept = 1'b0;

  // Cycle monitor: compares DUT outputs against the reference, then advances it.
  always @(negedge clk) begin
    if (rst_n) begin
      bit pop, acc, exp_rdy;
      pop = (exp_q.size() != 0) && bus.rsp_ready;
      exp_rdy = ((exp_q.size() + int'(iss_v)) < DEPTH) || (pop && !iss_v);
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_q.size() != 0));
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(exp_rdy));
      if (exp_q.size() != 0) begin
        chk("rsp_data",  64'(bus.rsp_data),  64'(exp_q[0].data));
        chk("rsp_flags", 64'(bus.rsp_flags), 64'(exp_q[0].flags));
        chk("rsp_err",   64'(bus.rsp_err),   64'(exp_q[0].err));
        chk("rsp_tag",   64'(bus.rsp_tag),   64'(exp_q[0].tag));
      end
      if (iss_v) begin
        chk("alu_a",  64'(bus.data_operandA),  64'(iss_a));
        chk("alu_b",  64'(bus.data_operandB),  64'(iss_b));
        chk("alu_op", 64'(bus.ctrl_ALUopcode), 64'(iss_op));
      end
      acc = bus.cmd_valid && bus.cmd_ready;
      last_accept = acc;
      if (pop) void'(exp_q.pop_front());
      if (iss_v) exp_q.push_back(iss_e);
      iss_v = acc;
      if (acc) begin
        iss_e  = ref_rsp(bus.cmd_opcode, bus.cmd_shamt, bus.cmd_a, bus.cmd_b, bus.cmd_tag);
        iss_a  = bus.cmd_a;
        iss_b  = bus.cmd_b;
        iss_op = bus.cmd_opcode;
      end
    end else begin
      last_accept = 1'b0;
    end
  end

  // Present one command and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [4:0] op, input logic [4:0] sh, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tag);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_shamt  = sh;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.cmd_tag    = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Directed latency check: nothing after the accept edge, response after the next one.
  task automatic expect_rsp2(input string nm, input logic [31:0] d, input logic [2:0] f,
                             input logic e, input logic [3:0] t);
    @(negedge clk);
    chk({nm, "_lat1"}, 64'(bus.rsp_valid), 64'(0));
    @(negedge clk);
    chk({nm, "_valid"}, 64'(bus.rsp_valid), 64'(1));
    chk({nm, "_data"},  64'(bus.rsp_data),  64'(d));
    chk({nm, "_flags"}, 64'(bus.rsp_flags), 64'(f));
    chk({nm, "_err"},   64'(bus.rsp_err),   64'(e));
    chk({nm, "_tag"},   64'(bus.rsp_tag),   64'(t));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rnd_op();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(6, 31));
    return 5'($urandom_range(0, 5));
  endfunction

  initial begin
    int n;
    bit done;
    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_shamt  = '0;
    bus.cmd_a      = '0;
    bus.cmd_b      = '0;
    bus.cmd_tag    = '0;
    bus.rsp_ready  = 1'b1;

    #2;
    chk("rst_rsp_valid", 64'(bus.rsp_valid),      64'(0));
    chk("rst_cmd_ready", 64'(bus.cmd_ready),      64'(0));
    chk("rst_alu_a",     64'(bus.data_operandA),  64'(0));
    chk("rst_alu_op",    64'(bus.ctrl_ALUopcode), 64'(0));
    chk("rst_rsp_data",  64'(bus.rsp_data),       64'(0));
    #15 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed ALU cases with an always-ready consumer.
    send(5'd0, 5'd0, 32'h7FFF_FFFF, 32'd1, 4'd3);
    expect_rsp2("add", 32'h8000_0000, 3'b101, 1'b0, 4'd3);
    send(5'd1, 5'd0, 32'd5, 32'd9, 4'd4);
    expect_rsp2("sub", 32'hFFFF_FFFC, 3'b011, 1'b0, 4'd4);
    send(5'd4, 5'd31, 32'd1, 32'd1, 4'd5);
    expect_rsp2("sll", 32'h8000_0000, 3'b000, 1'b0, 4'd5);
    send(5'd7, 5'd3, 32'h1234, 32'h99, 4'd9);
    expect_rsp2("ill", 32'h0, 3'b000, 1'b1, 4'd9);

    // Stall: stream with rsp_ready low, exactly DEPTH commands fit.
    bus.rsp_ready  = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_tag    = 4'd0;
    bus.cmd_opcode = 5'd0;
    bus.cmd_a      = 32'd100;
    bus.cmd_b      = 32'd7;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) n++;
      @(posedge clk);
      #1 bus.cmd_tag = 4'(n);
      bus.cmd_a = 32'(100 + n);
    end
    chk("stall_accepts", 64'(n), 64'(DEPTH));
    @(negedge clk);
    chk("stall_ready", 64'(bus.cmd_ready), 64'(0));
    chk("stall_head_tag", 64'(bus.rsp_tag), 64'(0));
    // Pop at full with nothing in issue: accept in the same cycle.
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("pop_accept", 64'(bus.cmd_ready), 64'(1));
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Reset with two queued responses and one command in issue.
    bus.rsp_ready = 1'b0;
    send(5'd2, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd1);
    send(5'd3, 5'd0, 32'h0000_00F0, 32'h0F00_0000, 4'd2);
    send(5'd5, 5'd4, 32'h8000_0010, 32'd3, 4'd3);
    rst_n = 1'b0;
    exp_q.delete();
    iss_v = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid),      64'(0));
    chk("mid_rst_rsp_data",  64'(bus.rsp_data),       64'(0));
    chk("mid_rst_alu_a",     64'(bus.data_operandA),  64'(0));
    chk("mid_rst_alu_op",    64'(bus.ctrl_ALUopcode), 64'(0));
    chk("mid_rst_cmd_ready", 64'(bus.cmd_ready),      64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(bus.rsp_valid), 64'(0));
    chk("post_rst_ready", 64'(bus.cmd_ready), 64'(1));
    @(posedge clk);
    #1;

    // Random traffic; a presented command is held until it is accepted.
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!bus.cmd_valid || last_accept) begin
        bus.cmd_valid  = ($urandom_range(0, 3) != 0);
        bus.cmd_opcode = rnd_op();
        bus.cmd_shamt  = 5'($urandom_range(0, 31));
        bus.cmd_a      = rnd_val();
        bus.cmd_b      = rnd_val();
        bus.cmd_tag    = 4'($urandom_range(0, 15));
      end
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end

    // Drain everything still in flight.
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!iss_v && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", 64'(done), 64'(1));
    @(negedge clk);
    chk("drain_valid", 64'(bus.rsp_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
